encoder_position_ctrl: RTL and testbench
========================================

Name: encoder_position_ctrl

Overview:
- Closed-loop positioning sequencer fed by the quadrature decoder's registered 2-bit direction code.
- Accumulates a signed position count from the direction code.
- Accepts move commands through a valid/ready handshake and drives the motor-bridge enables (forward/reverse) until the count settles at the target.
- Flags a stall fault if the encoder stops stepping while the motor is driven.

Parameters:
- POS_W, 16, position/target width (signed two's complement).
- DEADBAND, 0, allowed |target - pos| counted as "on target" (unsigned, less than 2^(POS_W-1)).
- SETTLE_CYC, 8, consecutive on-target cycles required before completion (at least 1).
- STALL_CYC, 1000, MOVE cycles without any encoder step before fault (at least 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dir  in  2  decoder step code: 01 = +1, 10 = -1, 00/11 = no step
- cmd_valid  in  1  move command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_target  in  POS_W  signed target position
- cmd_abort  in  1  abort current move
- zero  in  1  clear position (honoured only in IDLE)
- fault_clr  in  1  leave FAULT
- pos  out  POS_W  signed position count
- motor_fwd  out  1  drive forward
- motor_rev  out  1  drive reverse
- busy  out  1  high in MOVE or SETTLE
- done  out  1  one-cycle pulse on successful completion
- fault  out  1  high in FAULT

Behaviour:
- Reset is asynchronous, active-low; clock is clk. Reset values: pos=0, state=IDLE, target=0, counters=0, motor_fwd=0, motor_rev=0, done=0, fault=0, busy=0. cmd_ready=1 after reset, since it is combinational from IDLE.
- Reset asserted mid-move drops both motor enables immediately.
- Position is updated every cycle in every state:
  - dir=01: pos+1; dir=10: pos-1; 00/11: hold.
  - Wraps modulo 2^POS_W with no saturation.
  - zero=1 in IDLE sets pos=0 that cycle and overrides any simultaneous step.
  - zero is ignored outside IDLE.
- Error is err = target - pos_next, computed at POS_W+1 bits signed, so there is no overflow. "On" means |err| <= DEADBAND.
- State machine, with all state and outputs registered:
  - IDLE: cmd_ready = !cmd_abort. Handshake is cmd_valid & cmd_ready; it latches cmd_target and moves to MOVE next cycle, clearing the stall and settle counters. Motors off.
  - MOVE:
    - If on target: go to SETTLE, both motors 0 next cycle.
    - Else if err>0: motor_fwd=1, motor_rev=0.
    - Else: motor_rev=1, motor_fwd=0.
    - Dead time on reversal: if the required direction is opposite to the currently asserted motor, both are 0 for exactly one cycle before the new enable asserts.
    - Stall counter clears on any dir step (01/10), otherwise increments. Reaching STALL_CYC-1 without a step means next state is FAULT.
  - SETTLE: both motors 0; settle counter increments while on target. If not on target: back to MOVE with the settle counter cleared. After SETTLE_CYC consecutive on-target cycles: IDLE with done=1 for exactly that transition cycle.
  - FAULT: fault=1, motors 0, cmd_ready=0. fault_clr=1 goes to IDLE next cycle with fault=0. pos keeps tracking.
- cmd_abort in MOVE or SETTLE: IDLE next cycle, motors 0 that cycle, no done. Abort takes priority over settle completion, stall fault and reversal. Abort in FAULT is ignored.
- Invariants: motor_fwd & motor_rev is never 1; done only ever asserts on a SETTLE-to-IDLE transition; busy = (state==MOVE or SETTLE).
- Commands are not queued: cmd_valid while busy is ignored (cmd_ready=0).

Test Plan:
- Reset, then command target=+5, then feed dir=01 once every 4 cycles → motor_fwd=1 from the cycle after MOVE entry; pos steps 0..5; motors drop when pos=5; done pulses once 8 cycles later; cmd_ready returns to 1.
- pos=0, target=-3 with an overshoot to -4 (extra dir=10), DEADBAND=0 → motor_rev, then SETTLE, then back to MOVE. A reversal from rev to fwd shows exactly one cycle with both 0; ends at pos=-3 with done.
- Command target=100 with dir held at 00 → FAULT after STALL_CYC cycles: fault=1, motors 0, cmd_ready=0. fault_clr → IDLE next cycle, fault=0.
- pos=32767 (POS_W=16) plus one dir=01 → pos=-32768. Command target=-32768 from pos=32767 → err is computed wide, so motor_rev=1 (no overflow).
- Mid-MOVE cmd_abort together with the last step to target → IDLE, done stays 0. zero=1 during MOVE is ignored; zero=1 in IDLE with simultaneous dir=01 → pos=0.
- Assert rst_n low asynchronously while motor_fwd=1 → motor_fwd=0 immediately, pos=0, state IDLE.

Source files
------------

// File: rtl/encoder_position_ctrl_if.sv
// Move-command handshake between a position requester and the positioning sequencer.
// The master offers a signed target; the slave accepts it on cmd_valid & cmd_ready.
interface encoder_position_ctrl_if #(
  parameter int POS_W = 16
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic signed [POS_W-1:0] cmd_target;

  modport master (output cmd_valid, output cmd_target, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, output cmd_ready);
endinterface

// File: rtl/encoder_position_ctrl.sv
// Closed-loop positioning sequencer: tracks encoder steps, drives the motor bridge toward a
// commanded target, waits for the count to settle, and faults if the encoder stops stepping.
module encoder_position_ctrl #(
  parameter int POS_W      = 16,
  parameter int DEADBAND   = 0,
  parameter int SETTLE_CYC = 8,
  parameter int STALL_CYC  = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  encoder_position_ctrl_if.slave  cmd,
  input  logic [1:0]              dir_i,
  input  logic                    cmd_abort_i,
  input  logic                    zero_i,
  input  logic                    fault_clr_i,
  output logic signed [POS_W-1:0] pos_o,
  output logic                    motor_fwd_o,
  output logic                    motor_rev_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fault_o
);

  localparam int STALL_W  = $clog2(STALL_CYC + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE, FAULT} state_e;

  state_e                  state_q, state_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic signed [POS_W-1:0] target_q, target_d;
  logic [STALL_W-1:0]      stallCnt_q, stallCnt_d;
  logic [SETTLE_W-1:0]     settleCnt_q, settleCnt_d;
  logic                    motorFwd_q, motorFwd_d;
  logic                    motorRev_q, motorRev_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fault_q, fault_d;

  logic                    step;
  logic                    cmdReady;
  logic signed [POS_W:0]   err;
  logic [POS_W:0]          errMag;
  logic                    onTarget;
  logic                    errPos;

  assign step     = dir_i[0] ^ dir_i[1];
  assign cmdReady = (state_q == IDLE) && !cmd_abort_i;
  assign cmd.cmd_ready = cmdReady;

  // Error is taken one bit wider than the count so extreme target/position pairs cannot overflow.
  assign err      = {target_q[POS_W-1], target_q} - {pos_d[POS_W-1], pos_d};
  assign errMag   = err[POS_W] ? $unsigned(-err) : $unsigned(err);
  assign onTarget = (errMag <= (POS_W+1)'(DEADBAND));
  assign errPos   = !err[POS_W] && (err != '0);

  always_comb begin
    pos_d = pos_q;
    if ((state_q == IDLE) && zero_i) begin
      pos_d = '0;
    end else if (dir_i == 2'b01) begin
      pos_d = pos_q + POS_W'(1);
    end else if (dir_i == 2'b10) begin
      pos_d = pos_q - POS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      target_q    <= '0;
      stallCnt_q  <= '0;
      settleCnt_q <= '0;
      motorFwd_q  <= 1'b0;
      motorRev_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      target_q    <= target_d;
      stallCnt_q  <= stallCnt_d;
      settleCnt_q <= settleCnt_d;
      motorFwd_q  <= motorFwd_d;
      motorRev_q  <= motorRev_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  // Abort outranks everything in MOVE/SETTLE; FAULT only leaves on fault_clr.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    stallCnt_d  = stallCnt_q;
    settleCnt_d = settleCnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid && cmdReady) begin
          state_d     = MOVE;
          target_d    = cmd.cmd_target;
          stallCnt_d  = '0;
          settleCnt_d = '0;
        end
      end
      MOVE: begin
        if (cmd_abort_i) begin
          state_d = IDLE;
        end else if (onTarget) begin
          state_d     = SETTLE;
          settleCnt_d = '0;
        end else if (step) begin
          stallCnt_d = '0;
        end else if (stallCnt_q == STALL_W'(STALL_CYC - 1)) begin
          state_d = FAULT;
        end else begin
          stallCnt_d = stallCnt_q + STALL_W'(1);
        end
      end
      SETTLE: begin
        if (cmd_abort_i) begin
          state_d = IDLE;
        end else if (!onTarget) begin
          state_d     = MOVE;
          settleCnt_d = '0;
          stallCnt_d  = '0;
        end else if (settleCnt_q == SETTLE_W'(SETTLE_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          settleCnt_d = settleCnt_q + SETTLE_W'(1);
        end
      end
      FAULT: begin
        if (fault_clr_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A freshly latched target is not yet in err, so drive only once MOVE continues or resumes;
  // the opposite enable must be low for a cycle before a new one asserts.
  always_comb begin
    motorFwd_d = 1'b0;
    motorRev_d = 1'b0;
    if ((state_d == MOVE) && (state_q != IDLE)) begin
      if (errPos) begin
        motorFwd_d = !motorRev_q;
      end else begin
        motorRev_d = !motorFwd_q;
      end
    end
    done_d  = (state_q == SETTLE) && (state_d == IDLE) && !cmd_abort_i;
    fault_d = (state_d == FAULT);
    busy_d  = (state_d == MOVE) || (state_d == SETTLE);
  end

  assign pos_o       = pos_q;
  assign motor_fwd_o = motorFwd_q;
  assign motor_rev_o = motorRev_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_encoder_position_ctrl.sv
// Bench for encoder_position_ctrl: directed moves; a monitor pops the expected record each
// time the registered output vector {fwd,rev,done,fault,busy} changes.
module tb_encoder_position_ctrl;
  localparam int POS_W      = 16;
  localparam int DEADBAND   = 0;
  localparam int SETTLE_CYC = 8;
  localparam int STALL_CYC  = 1000;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [1:0]              dir = 2'b00;
  logic                    cmdAbort = 1'b0;
  logic                    zero = 1'b0;
  logic                    faultClr = 1'b0;
  logic signed [POS_W-1:0] pos;
  logic                    motorFwd, motorRev, busy, done, fault;

  encoder_position_ctrl_if #(.POS_W(POS_W)) cmdIf ();

  encoder_position_ctrl #(
    .POS_W(POS_W), .DEADBAND(DEADBAND), .SETTLE_CYC(SETTLE_CYC), .STALL_CYC(STALL_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmdIf), .dir_i(dir), .cmd_abort_i(cmdAbort),
    .zero_i(zero), .fault_clr_i(faultClr), .pos_o(pos), .motor_fwd_o(motorFwd),
    .motor_rev_o(motorRev), .busy_o(busy), .done_o(done), .fault_o(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] vec;
    bit         chkPos;
    int         pos;
    int         gap;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  bit   monEn = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] d, input logic z, input logic ab,
                               input logic fc, input logic v, input int tgt);
    dir                 = d;
    zero                = z;
    cmdAbort            = ab;
    faultClr            = fc;
    cmdIf.cmd_valid     = v;
    cmdIf.cmd_target    = POS_W'(tgt);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectEvent(input string name, input logic [4:0] vec, input bit chkPos,
                             input int p, input int gap);
    exp_t e;
    e.name = name; e.vec = vec; e.chkPos = chkPos; e.pos = p; e.gap = gap;
    expQ.push_back(e);
  endtask

  // Monitor: every change of the output vector is one DUT response to score.
  initial begin
    logic [4:0] prevVec, curVec;
    int         lastCyc;
    exp_t       e;
    prevVec = '0;
    lastCyc = 0;
    wait (monEn);
    forever begin
      @(negedge clk);
      curVec = {motorFwd, motorRev, done, fault, busy};
      if (curVec !== prevVec) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_event: actual vec=%b pos=%0d required no change",
                   curVec, pos);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, "_vec"}, {27'd0, curVec}, {27'd0, e.vec});
          if (e.chkPos) checkOutput({e.name, "_pos"}, pos, e.pos);
          if (e.gap >= 0) checkOutput({e.name, "_gap"}, cycle - lastCyc, e.gap);
        end
        prevVec = curVec;
        lastCyc = cycle;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(2'b00, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    tick(3);
    checkOutput("rst_pos", pos, 0);
    checkOutput("rst_fwd", motorFwd, 0);
    checkOutput("rst_rev", motorRev, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_ready", cmdIf.cmd_ready, 1);
    rst_n = 1'b1;
    monEn = 1'b1;
    tick(2);

    // Forward move to +5, one encoder step every four cycles.
    expectEvent("s1_busy",   5'b00001, 1, 0, -1);
    expectEvent("s1_fwd",    5'b10001, 1, 0, 1);
    expectEvent("s1_settle", 5'b00001, 1, 5, -1);
    expectEvent("s1_done",   5'b00100, 1, 5, 8);
    expectEvent("s1_idle",   5'b00000, 1, 5, 1);
    checkOutput("s1_ready_before", cmdIf.cmd_ready, 1);
    applyStimulus(2'b00, 0, 0, 0, 1, 5);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, 5);
    for (int i = 0; i < 5; i++) begin
      tick(3);
      applyStimulus(2'b01, 0, 0, 0, 0, 5);
      tick(1);
      applyStimulus(2'b00, 0, 0, 0, 0, 5);
    end
    tick(15);
    checkOutput("s1_ready_after", cmdIf.cmd_ready, 1);
    checkOutput("s1_pos_final", pos, 5);

    applyStimulus(2'b00, 0, 1, 0, 0, 0);
    #1 checkOutput("idle_abort_ready", cmdIf.cmd_ready, 0);
    applyStimulus(2'b01, 1, 0, 0, 0, 0);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, 0);
    checkOutput("zero_over_step", pos, 0);

    // Reverse move to -3 with a one-step overshoot during the first settle cycle.
    expectEvent("s2_busy",    5'b00001, 1, 0, -1);
    expectEvent("s2_rev",     5'b01001, 1, 0, 1);
    expectEvent("s2_settle",  5'b00001, 1, -3, -1);
    expectEvent("s2_fwd",     5'b10001, 1, -4, 1);
    expectEvent("s2_settle2", 5'b00001, 1, -3, -1);
    expectEvent("s2_done",    5'b00100, 1, -3, 8);
    expectEvent("s2_idle",    5'b00000, 1, -3, 1);
    applyStimulus(2'b00, 0, 0, 0, 1, -3);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, -3);
    for (int i = 0; i < 2; i++) begin
      tick(3);
      applyStimulus(2'b10, 0, 0, 0, 0, -3);
      tick(1);
      applyStimulus(2'b00, 0, 0, 0, 0, -3);
    end
    tick(3);
    applyStimulus(2'b10, 0, 0, 0, 0, -3);
    tick(2);
    applyStimulus(2'b00, 0, 0, 0, 0, -3);
    tick(3);
    applyStimulus(2'b01, 0, 0, 0, 0, -3);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, -3);
    tick(15);

    // Stall: target far away, encoder never steps.
    expectEvent("s3_busy",  5'b00001, 1, -3, -1);
    expectEvent("s3_fwd",   5'b10001, 1, -3, 1);
    expectEvent("s3_fault", 5'b00010, 1, -3, STALL_CYC - 1);
    expectEvent("s3_clear", 5'b00000, 1, -2, -1);
    applyStimulus(2'b00, 0, 0, 0, 1, 100);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, 100);
    tick(STALL_CYC + 5);
    applyStimulus(2'b00, 0, 1, 0, 1, 7);
    #1 checkOutput("fault_ready", cmdIf.cmd_ready, 0);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, 7);
    checkOutput("fault_abort_ignored", fault, 1);
    applyStimulus(2'b01, 0, 0, 0, 0, 7);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, 7);
    checkOutput("fault_pos_tracks", pos, -2);
    applyStimulus(2'b00, 0, 0, 1, 0, 7);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, 7);
    tick(2);
    checkOutput("s3_ready_after", cmdIf.cmd_ready, 1);

    // Wrap-around at the positive limit.
    applyStimulus(2'b00, 1, 0, 0, 0, 0);
    tick(1);
    applyStimulus(2'b01, 0, 0, 0, 0, 0);
    tick(32767);
    applyStimulus(2'b00, 0, 0, 0, 0, 0);
    checkOutput("pos_max", pos, 32767);
    applyStimulus(2'b01, 0, 0, 0, 0, 0);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, 0);
    checkOutput("pos_wrap_up", pos, -32768);
    applyStimulus(2'b10, 0, 0, 0, 0, 0);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, 0);
    checkOutput("pos_wrap_down", pos, 32767);

    // Extreme target needs the wide error (reverse); abort lands with the final step.
    expectEvent("s4_busy",  5'b00001, 1, 32767, -1);
    expectEvent("s4_rev",   5'b01001, 1, 32767, 1);
    expectEvent("s4_abort", 5'b00000, 1, -32768, -1);
    applyStimulus(2'b00, 0, 0, 0, 1, -32768);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, -32768);
    tick(3);
    applyStimulus(2'b01, 0, 1, 0, 0, -32768);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, -32768);
    tick(12);
    checkOutput("s4_pos_after_abort", pos, -32768);

    // zero is ignored in MOVE; then asynchronous reset while driving forward.
    expectEvent("s5_busy",  5'b00001, 1, -32768, -1);
    expectEvent("s5_fwd",   5'b10001, 1, -32768, 1);
    expectEvent("s5_reset", 5'b00000, 1, 0, -1);
    applyStimulus(2'b00, 0, 0, 0, 1, -32766);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, -32766);
    tick(3);
    applyStimulus(2'b00, 1, 0, 0, 0, -32766);
    tick(1);
    applyStimulus(2'b00, 0, 0, 0, 0, -32766);
    checkOutput("move_zero_ignored", pos, -32768);
    checkOutput("move_fwd_before_rst", motorFwd, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_fwd", motorFwd, 0);
    checkOutput("async_rst_pos", pos, 0);
    checkOutput("async_rst_busy", busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checkOutput("post_rst_ready", cmdIf.cmd_ready, 1);

    tick(5);
    checkOutput("events_outstanding", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
